// File: rtl/flag_stack.sv
// Bank of live 1-bit flags with a LIFO of saved flag contexts.
// Push saves the pre-edge flags, pop restores them; misuse sets a sticky error.
module flag_stack #(
  parameter int NFLAGS = 3,
  parameter int DEPTH  = 4,
  parameter int LW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NFLAGS-1:0] write,
  input  logic [NFLAGS-1:0] in,
  input  logic              push,
  input  logic              pop,
  input  logic              clr_err,
  output logic [NFLAGS-1:0] flag_out,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              empty,
  output logic              err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NFLAGS-1:0] flags_q, flags_d;
  logic [LW-1:0]     level_q, level_d;
  logic              err_q, err_d;
  logic [NFLAGS-1:0] stk_q [DEPTH];

  logic [NFLAGS-1:0] written;
  logic [AW-1:0]     wr_idx, top_idx, store_idx;
  logic              do_store;
  logic              full_w, empty_w;

  assign full_w  = (level_q == LW'(DEPTH));
  assign empty_w = (level_q == '0);
  assign wr_idx  = AW'(level_q);
  assign top_idx = AW'(level_q - LW'(1));
  assign written = (flags_q & ~write) | (in & write);

  always_comb begin
    flags_d   = written;
    level_d   = level_q;
    err_d     = err_q & ~clr_err;
    do_store  = 1'b0;
    store_idx = wr_idx;
    if (push && pop && !empty_w) begin
      // Swap live flags with the top context; writes are dropped.
      flags_d   = stk_q[top_idx];
      do_store  = 1'b1;
      store_idx = top_idx;
    end else if (push) begin
      if (!full_w) begin
        do_store = 1'b1;
        level_d  = level_q + LW'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (pop) begin
      if (!empty_w) begin
        flags_d = stk_q[top_idx];
        level_d = level_q - LW'(1);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  // Context storage needs no reset: entries at or above level are never observed.
  always_ff @(posedge clk) begin
    if (do_store) stk_q[store_idx] <= flags_q;
  end

  assign flag_out = flags_q;
  assign level    = level_q;
  assign full     = full_w;
  assign empty    = empty_w;
  assign err      = err_q;

endmodule

// File: tb/tb_flag_stack.sv
// Scoreboard bench for flag_stack: the driver queues hand-computed results,
// a negedge monitor pops and compares them once they are due.
module tb_flag_stack;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] write = '0;
  logic [2:0] in_s  = '0;
  logic       push = 1'b0, pop = 1'b0, clr_err = 1'b0;
  logic [2:0] flag_out;
  logic [2:0] level;
  logic       full, empty, err;

  flag_stack #(.NFLAGS(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .write(write), .in(in_s), .push(push), .pop(pop),
    .clr_err(clr_err), .flag_out(flag_out), .level(level), .full(full),
    .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    string      nm;
    logic [2:0] f;
    logic [2:0] l;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string nm, input logic [2:0] f, input logic [2:0] l,
                           input logic e);
    check({nm, ".flag_out"}, 8'(flag_out), 8'(f));
    check({nm, ".level"},    8'(level),    8'(l));
    check({nm, ".err"},      8'(err),      8'(e));
    check({nm, ".full"},     8'(full),     8'(l == 3'd4));
    check({nm, ".empty"},    8'(empty),    8'(l == 3'd0));
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    while (q.size() > 0 && q[0].due <= cyc) begin
      x = q.pop_front();
      check_all(x.nm, x.f, x.l, x.e);
    end
  end

  // One clocked operation; expected outputs are visible after the next rising edge.
  task automatic step(input string nm, input logic [2:0] w, input logic [2:0] i,
                      input logic pu, input logic po, input logic ce,
                      input logic [2:0] ef, input logic [2:0] el, input logic ee);
    exp_t x;
    @(negedge clk);
    write = w; in_s = i; push = pu; pop = po; clr_err = ce;
    x.due = cyc + 1; x.nm = nm; x.f = ef; x.l = el; x.e = ee;
    q.push_back(x);
    @(posedge clk);
    #1;
    write = '0; in_s = '0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    #3;
    check_all("reset", 3'b000, 3'd0, 1'b0);
    @(posedge clk); #2 rst = 1'b1;

    // Per-flag write enables
    step("wr1",  3'b101, 3'b111, 0, 0, 0, 3'b101, 3'd0, 0);
    step("wr2",  3'b010, 3'b000, 0, 0, 0, 3'b101, 3'd0, 0);
    // Push with same-cycle write, then pop restores the old value
    step("set011", 3'b111, 3'b011, 0, 0, 0, 3'b011, 3'd0, 0);
    step("pushw",  3'b111, 3'b100, 1, 0, 0, 3'b100, 3'd1, 0);
    step("pop1",   3'b111, 3'b111, 0, 1, 0, 3'b011, 3'd0, 0);
    // Swap with level 1
    step("set110", 3'b111, 3'b110, 0, 0, 0, 3'b110, 3'd0, 0);
    step("push110",3'b111, 3'b001, 1, 0, 0, 3'b001, 3'd1, 0);
    step("swap",   3'b111, 3'b111, 1, 1, 0, 3'b110, 3'd1, 0);
    step("popswap",3'b000, 3'b000, 0, 1, 0, 3'b001, 3'd0, 0);
    // Underflow with write, sticky err, clear vs. new error priority
    step("uflow",  3'b110, 3'b110, 0, 1, 0, 3'b111, 3'd0, 1);
    step("hold",   3'b000, 3'b000, 0, 0, 0, 3'b111, 3'd0, 1);
    step("clr",    3'b000, 3'b000, 0, 0, 1, 3'b111, 3'd0, 0);
    step("clrnew", 3'b000, 3'b000, 0, 1, 1, 3'b111, 3'd0, 1);
    step("clr2",   3'b000, 3'b000, 0, 0, 1, 3'b111, 3'd0, 0);
    // Fill to depth, overflow still applies the write
    step("v1",  3'b111, 3'b001, 0, 0, 0, 3'b001, 3'd0, 0);
    step("p1",  3'b000, 3'b000, 1, 0, 0, 3'b001, 3'd1, 0);
    step("v2",  3'b111, 3'b010, 0, 0, 0, 3'b010, 3'd1, 0);
    step("p2",  3'b000, 3'b000, 1, 0, 0, 3'b010, 3'd2, 0);
    step("v3",  3'b111, 3'b011, 0, 0, 0, 3'b011, 3'd2, 0);
    step("p3",  3'b000, 3'b000, 1, 0, 0, 3'b011, 3'd3, 0);
    step("v4",  3'b111, 3'b100, 0, 0, 0, 3'b100, 3'd3, 0);
    step("p4",  3'b000, 3'b000, 1, 0, 0, 3'b100, 3'd4, 0);
    step("v5",  3'b111, 3'b101, 0, 0, 0, 3'b101, 3'd4, 0);
    step("p5",  3'b111, 3'b000, 1, 0, 0, 3'b000, 3'd4, 1);
    step("pop4",3'b000, 3'b000, 0, 1, 0, 3'b100, 3'd3, 1);
    step("pop3",3'b000, 3'b000, 0, 1, 0, 3'b011, 3'd2, 1);
    step("pop2",3'b000, 3'b000, 0, 1, 0, 3'b010, 3'd1, 1);
    step("pop1b",3'b000,3'b000, 0, 1, 0, 3'b001, 3'd0, 1);
    step("clr3",3'b000, 3'b000, 0, 0, 1, 3'b001, 3'd0, 0);
    // Push+pop while empty acts as a plain push
    step("pp0", 3'b111, 3'b110, 1, 1, 0, 3'b110, 3'd1, 0);
    step("pa",  3'b000, 3'b000, 1, 0, 0, 3'b110, 3'd2, 0);
    step("pb",  3'b000, 3'b000, 1, 0, 0, 3'b110, 3'd3, 0);

    // Asynchronous reset between edges with level 3
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check_all("async_rst", 3'b000, 3'd0, 1'b0);
    @(posedge clk); #2 rst = 1'b1;
    step("rel_pop", 3'b001, 3'b001, 0, 1, 0, 3'b001, 3'd0, 1);
    step("rel_clr", 3'b000, 3'b000, 0, 0, 1, 3'b001, 3'd0, 0);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/flag_stack.md
FLAG_STACK -- requirements
Module: flag_stack

Interface
REQ-001 Parameter NFLAGS, default 3: number of independent 1-bit flags, legal range 1..16.
REQ-002 Parameter DEPTH, default 4: number of saved flag contexts, legal range 1..16.
REQ-003 Parameter LW, derived as $clog2(DEPTH+1): width of the level output.
REQ-004 clk  in  1  Single clock; all state changes on rising edge.
REQ-005 rst  in  1  Reset, asynchronous, active-low.
REQ-006 write  in  NFLAGS  Per-flag write enable; bit i enables update of flag i.
REQ-007 in  in  NFLAGS  Per-flag new value; bit i feeds flag i.
REQ-008 push  in  1  Save the current live flags onto the context stack.
REQ-009 pop  in  1  Restore the live flags from the top stack entry.
REQ-010 clr_err  in  1  Clear the sticky error flag.
REQ-011 flag_out  out  NFLAGS  Live flag values; bit i is flag i, driven directly from registers.
REQ-012 level  out  LW  Number of valid stack entries, 0..DEPTH.
REQ-013 full  out  1  High when level==DEPTH.
REQ-014 empty  out  1  High when level==0.
REQ-015 err  out  1  Sticky overflow/underflow indicator.

Function
REQ-016 The block SHALL hold NFLAGS live flag registers and a DEPTH-entry LIFO of NFLAGS-bit contexts.
REQ-017 Live update: with no effective pop, flag i SHALL load in[i] on the clock edge where write[i]=1; otherwise it SHALL hold.
REQ-018 Push, when level<DEPTH: the pre-edge flag_out value (before any same-cycle write) SHALL be stored at index level, and level SHALL increment by 1.
REQ-019 A push SHALL NOT suppress a same-cycle write; the live flags take the written values and the stack takes the old values.
REQ-020 Pop, when level>0: flag_out SHALL load entry level-1, level SHALL decrement by 1, and all same-cycle writes SHALL be ignored.
REQ-021 Push and pop in the same cycle with level>0: the live flags and the top entry SHALL swap (flag_out<=top, top<=old flag_out), level SHALL be unchanged, and writes SHALL be ignored.
REQ-022 Push and pop in the same cycle with level==0: the cycle SHALL behave as a push alone (REQ-018, REQ-019), and err SHALL NOT set.
REQ-023 Push when full without pop: the stack and level SHALL be unchanged, err SHALL set, and the write SHALL still apply.
REQ-024 Pop when empty without push: flags and level SHALL be unchanged, the write SHALL still apply, and err SHALL set.
REQ-025 err SHALL hold until clr_err=1; if clr_err and a new error occur in the same cycle, err SHALL be 1.
REQ-026 full, empty and level SHALL be combinational decodes of the registered count, with no added latency.
REQ-027 All results SHALL be visible on the outputs in the cycle after the triggering edge; latency is 1 clock.
REQ-028 Stack entries at index >= level SHALL NOT affect any output.

Reset
REQ-029 While rst=0, the block SHALL asynchronously force flag_out=0, level=0, and err=0, so that empty=1 and full=0.
REQ-030 Stack entry contents SHALL NOT require reset.
REQ-031 Deassertion of rst SHALL take effect at the next rising edge of clk, and inputs at that edge SHALL be honoured.
REQ-032 Reset asserted mid-sequence SHALL discard all saved contexts.

Verification
REQ-033 Set NFLAGS=3 and DEPTH=4, apply write=3'b101, in=3'b111, then write=3'b010, in=3'b000 -> flag_out=3'b101 after the first edge and 3'b101 after the second.
REQ-034 With flag_out=3'b011, apply push together with write=3'b111, in=3'b100, then pop -> flag_out=3'b100 and level=1 after the first edge, then flag_out=3'b011 and level=0.
REQ-035 Apply 5 pushes with values 1,2,3,4,5 -> level=4, full=1, and err=1 after the 5th push; then 4 pops -> flag_out=4,3,2,1 in turn, empty=1.
REQ-036 Apply pop at reset with write=3'b001, in=3'b001 -> flag_out=3'b001, level=0, err=1; then clr_err -> err=0.
REQ-037 With level=1, top=3'b110, flag_out=3'b001, apply push and pop together -> flag_out=3'b110, top=3'b001, level=1, err=0.
REQ-038 With level=3, drive rst low between clock edges -> flag_out=0 and level=0 immediately, without waiting for clk.
